chip8_mem_arbiter: RTL and testbench
====================================

// Module: chip8_mem_arbiter
// PURPOSE
//  Owns the single 4 KB CHIP-8 RAM and shares it between three masters: CPU fetch/data port,
//  host ROM loader (byte stream) and sprite-fetch engine (DXYN row reads). CPU has zero-latency
//  absolute priority; loader is exclusive during a load session and holds the CPU in reset;
//  sprite engine takes idle cycles only. Sits between chip8_cpu and the RAM macro.
// PARAMETERS
//  LOAD_BASE    12'h200  first RAM address written by a load session
//  HOLD_CYCLES  2        cycles cpu_hold is asserted before first loader write is accepted
//  STARVE_LIMIT 8        consecutive denied sprite-request cycles that raise spr_starve
// PORTS
//  clk            in   1   system clock, all state on rising edge
//  reset_n        in   1   asynchronous, active-low reset
//  cpu_mem_read   in   1   CPU read strobe
//  cpu_mem_write  in   1   CPU write strobe
//  cpu_mem_addr   in   12  CPU address
//  cpu_mem_wdata  in   8   CPU write data
//  cpu_mem_rdata  out  8   CPU read data (combinational from ram_rdata)
//  cpu_hold       out  1   active-high reset to chip8_cpu during load session
//  ld_start       in   1   pulse: begin load session
//  ld_valid       in   1   loader byte valid
//  ld_data        in   8   loader byte
//  ld_last        in   1   qualifies ld_valid: final byte of image
//  ld_ready       out  1   arbiter accepts loader byte this cycle
//  ld_busy        out  1   load session in progress
//  ld_err         out  1   sticky: image overran 12'hFFF; cleared by next ld_start
//  spr_req        in   1   sprite read request (held until spr_gnt)
//  spr_addr       in   12  sprite read address
//  spr_gnt        out  1   request granted this cycle (combinational)
//  spr_rvalid     out  1   registered: spr_rdata valid, 1 cycle after spr_gnt
//  spr_rdata      out  8   registered sprite read data
//  spr_starve     out  1   sprite denied >= STARVE_LIMIT consecutive cycles
//  ram_en/ram_we  out  1   RAM enable / write enable
//  ram_addr       out  12  RAM address;  ram_wdata out 8;  ram_rdata in 8 (async read)
// BEHAVIOUR
//  RAM model: asynchronous read, synchronous write. RAM-side outputs are a combinational mux.
//  FSM: RUN -> (ld_start) HOLD -> (HOLD_CYCLES elapsed) LOAD -> (ld_valid&ld_ready&ld_last) RELEASE -> RUN.
//  RUN: CPU strobe present -> CPU owns RAM; write beats read if both high. Else spr_req -> spr_gnt=1.
//  HOLD: cpu_hold=1, ld_busy=1, ld_ready=0, CPU strobes ignored; sprite may use RAM.
//  LOAD: cpu_hold=1, ld_ready=1 unless ld_err; accepted byte written to LOAD_BASE+count, count++.
//   Sprite granted only in cycles with no ld_valid. Write at addr 12'hFFF sets ld_err; further
//   bytes dropped (ld_ready=0) until ld_last arrives with ld_valid (then RELEASE, no write).
//  RELEASE: one cycle, cpu_hold=1, ld_busy=0, ld_ready=0; cpu_hold drops on entry to RUN, CPU restarts at 0x200.
//  ld_start outside RUN is ignored. ld_start in RUN same cycle as CPU access: access completes, then HOLD.
//  spr_rvalid/spr_rdata: registered copy of grant/ram_rdata; spr_rdata holds last value otherwise.
//  Starve counter: +1 per cycle spr_req&!spr_gnt, saturates at STARVE_LIMIT, clears on grant or !spr_req.
//  Reset (any state, incl. mid-load): state RUN, count 0, cpu_hold=0, ld_busy=0, ld_err=0,
//   ld_ready=0, spr_rvalid=0, spr_rdata=0, spr_starve=0; ram_en/ram_we=0 with no requests.
// TESTING
//  1 CPU read 0x200 while spr_req -> ram_addr=0x200 same cycle, spr_gnt=0; next idle cycle spr_gnt=1.
//  2 ld_start, 4 bytes A0 B1 C2 D3 (last on D3) -> cpu_hold high 2 cycles pre-accept, RAM 0x200..0x203
//    = A0..D3, RELEASE 1 cycle, cpu_hold low, ld_busy low.
//  3 spr_req at 0x050 during LOAD with ld_valid gaps -> grants only in gap cycles, spr_rvalid next
//    cycle, spr_rdata = RAM[0x050].
//  4 CPU reads every cycle, spr_req held 10 cycles -> spr_starve rises on 8th denied cycle, drops on grant.
//  5 image of 3585 bytes -> byte 3584 written to 0xFFF, ld_err=1, byte 3585 (ld_last) dropped, RUN.
//  6 reset_n low mid-LOAD (async) -> cpu_hold, ld_busy, ld_ready low immediately; restart in RUN.

Source files
------------

// File: rtl/chip8_mem_arbiter.sv
// Shares the single 4 KB CHIP-8 RAM between the CPU, the host ROM loader and the sprite fetcher.
// The CPU wins every cycle it strobes, the loader owns RAM during a session, and sprites use idle cycles.
module chip8_mem_arbiter #(
    parameter logic [11:0] LOAD_BASE    = 12'h200,
    parameter int          HOLD_CYCLES  = 2,
    parameter int          STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_mem_read,
    input  logic        cpu_mem_write,
    input  logic [11:0] cpu_mem_addr,
    input  logic [7:0]  cpu_mem_wdata,
    output logic [7:0]  cpu_mem_rdata,
    output logic        cpu_hold,
    input  logic        ld_start,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        ld_busy,
    output logic        ld_err,
    input  logic        spr_req,
    input  logic [11:0] spr_addr,
    output logic        spr_gnt,
    output logic        spr_rvalid,
    output logic [7:0]  spr_rdata,
    output logic        spr_starve,
    output logic        ram_en,
    output logic        ram_we,
    output logic [11:0] ram_addr,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HOLD,
        ST_LOAD,
        ST_RELEASE
    } state_t;

    state_t          state;
    logic [HW-1:0]   hold_cnt;
    logic [11:0]     load_cnt;
    logic [SW-1:0]   starve_cnt;
    logic            cpu_access;
    logic            ld_accept;
    logic [11:0]     load_addr;

    assign cpu_access    = (state == ST_RUN) && (cpu_mem_read || cpu_mem_write);
    assign ld_ready      = (state == ST_LOAD) && !ld_err;
    assign ld_accept     = ld_valid && ld_ready;
    assign load_addr     = LOAD_BASE + load_cnt;
    assign cpu_mem_rdata = ram_rdata;
    assign spr_starve    = (starve_cnt == SW'(STARVE_LIMIT));

    // Sprites only ever get cycles nobody else wants.
    always_comb begin
        spr_gnt = 1'b0;
        case (state)
            ST_RUN:     spr_gnt = spr_req && !cpu_access;
            ST_HOLD:    spr_gnt = spr_req;
            ST_LOAD:    spr_gnt = spr_req && !ld_valid;
            ST_RELEASE: spr_gnt = spr_req;
            default:    spr_gnt = 1'b0;
        endcase
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = 12'h000;
        ram_wdata = 8'h00;
        if (ld_accept) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = load_addr;
            ram_wdata = ld_data;
        end else if (cpu_access) begin
            ram_en    = 1'b1;
            ram_we    = cpu_mem_write;
            ram_addr  = cpu_mem_addr;
            ram_wdata = cpu_mem_write ? cpu_mem_wdata : 8'h00;
        end else if (spr_gnt) begin
            ram_en   = 1'b1;
            ram_addr = spr_addr;
        end
    end

    // Load-session FSM; a byte landing on 0xFFF poisons the rest of the image until ld_last.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_RUN;
            hold_cnt <= '0;
            load_cnt <= 12'h000;
            ld_err   <= 1'b0;
            cpu_hold <= 1'b0;
            ld_busy  <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (ld_start) begin
                        state    <= ST_HOLD;
                        hold_cnt <= '0;
                        load_cnt <= 12'h000;
                        ld_err   <= 1'b0;
                        cpu_hold <= 1'b1;
                        ld_busy  <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                        state <= ST_LOAD;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                ST_LOAD: begin
                    if (ld_accept) begin
                        load_cnt <= load_cnt + 12'd1;
                        if (load_addr == 12'hFFF) begin
                            ld_err <= 1'b1;
                        end
                        if (ld_last) begin
                            state   <= ST_RELEASE;
                            ld_busy <= 1'b0;
                        end
                    end else if (ld_err && ld_valid && ld_last) begin
                        state   <= ST_RELEASE;
                        ld_busy <= 1'b0;
                    end
                end
                ST_RELEASE: begin
                    state    <= ST_RUN;
                    cpu_hold <= 1'b0;
                end
                default: begin
                    state    <= ST_RUN;
                    cpu_hold <= 1'b0;
                    ld_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Sprite read return path and starvation tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spr_rvalid <= 1'b0;
            spr_rdata  <= 8'h00;
            starve_cnt <= '0;
        end else begin
            spr_rvalid <= spr_gnt;
            if (spr_gnt) begin
                spr_rdata <= ram_rdata;
            end
            if (!spr_req || spr_gnt) begin
                starve_cnt <= '0;
            end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Directed/randomized bench for chip8_mem_arbiter with a behavioural RAM and an expected-memory model.
module tb_chip8_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_mem_read, cpu_mem_write;
    logic [11:0] cpu_mem_addr;
    logic [7:0]  cpu_mem_wdata, cpu_mem_rdata;
    logic        cpu_hold;
    logic        ld_start, ld_valid, ld_last, ld_ready, ld_busy, ld_err;
    logic [7:0]  ld_data;
    logic        spr_req, spr_gnt, spr_rvalid, spr_starve;
    logic [11:0] spr_addr;
    logic [7:0]  spr_rdata;
    logic        ram_en, ram_we;
    logic [11:0] ram_addr;
    logic [7:0]  ram_wdata, ram_rdata;

    logic [7:0]  ram     [4096];
    logic [7:0]  ref_mem [4096];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign ram_rdata = ram[ram_addr];
    always @(posedge clk) begin
        if (ram_en && ram_we) ram[ram_addr] <= ram_wdata;
    end

    chip8_mem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
        .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
        .cpu_mem_rdata(cpu_mem_rdata), .cpu_hold(cpu_hold),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_err(ld_err),
        .spr_req(spr_req), .spr_addr(spr_addr), .spr_gnt(spr_gnt),
        .spr_rvalid(spr_rvalid), .spr_rdata(spr_rdata), .spr_starve(spr_starve),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    task automatic check_output(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_addr(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic rd, input logic wr, input logic [11:0] ca,
                                  input logic [7:0] cd, input logic sreq, input logic [11:0] sa,
                                  input logic lstart, input logic lvalid, input logic [7:0] ldat,
                                  input logic llast);
        cpu_mem_read  = rd;
        cpu_mem_write = wr;
        cpu_mem_addr  = ca;
        cpu_mem_wdata = cd;
        spr_req       = sreq;
        spr_addr      = sa;
        ld_start      = lstart;
        ld_valid      = lvalid;
        ld_data       = ldat;
        ld_last       = llast;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic skip_hold();
        for (int i = 0; i < 2; i++) begin
            idle();
            step();
        end
    endtask

    initial begin
        logic [11:0] saddr, wa, ea;
        logic [7:0]  d;
        logic [7:0]  img4 [4];
        logic        v, exp_gnt, prev_gnt;
        int          sent;

        img4[0] = 8'hA0; img4[1] = 8'hB1; img4[2] = 8'hC2; img4[3] = 8'hD3;
        for (int i = 0; i < 4096; i++) begin
            ram[i]     = 8'($urandom);
            ref_mem[i] = ram[i];
        end

        // Reset values
        reset_n = 1'b0;
        idle();
        check_output("rst_cpu_hold", cpu_hold, 1'b0);
        check_output("rst_ld_busy", ld_busy, 1'b0);
        check_output("rst_ld_ready", ld_ready, 1'b0);
        check_output("rst_ld_err", ld_err, 1'b0);
        check_output("rst_spr_rvalid", spr_rvalid, 1'b0);
        check_byte("rst_spr_rdata", spr_rdata, 8'h00);
        check_output("rst_spr_starve", spr_starve, 1'b0);
        check_output("rst_ram_en", ram_en, 1'b0);
        check_output("rst_ram_we", ram_we, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // CPU read has priority over a pending sprite request
        saddr = 12'($urandom_range(0, 511));
        apply_stimulus(1'b1, 1'b0, 12'h200, 8'h00, 1'b1, saddr, 1'b0, 1'b0, 8'h00, 1'b0);
        check_addr("t1_cpu_addr", ram_addr, 12'h200);
        check_output("t1_cpu_en", ram_en, 1'b1);
        check_output("t1_cpu_we", ram_we, 1'b0);
        check_output("t1_spr_denied", spr_gnt, 1'b0);
        check_byte("t1_cpu_rdata", cpu_mem_rdata, ref_mem[12'h200]);
        step();
        apply_stimulus(1'b0, 1'b0, 12'h000, 8'h00, 1'b1, saddr, 1'b0, 1'b0, 8'h00, 1'b0);
        check_output("t1_spr_gnt", spr_gnt, 1'b1);
        check_addr("t1_spr_addr", ram_addr, saddr);
        step();
        idle();
        check_output("t1_spr_rvalid", spr_rvalid, 1'b1);
        check_byte("t1_spr_rdata", spr_rdata, ref_mem[saddr]);
        check_output("t1_spr_gnt_off", spr_gnt, 1'b0);
        step();
        check_output("t1_rvalid_drop", spr_rvalid, 1'b0);
        check_byte("t1_rdata_hold", spr_rdata, ref_mem[saddr]);

        // Simultaneous CPU read and write: the write wins
        wa = 12'($urandom_range(12'h300, 12'h3FF));
        d  = 8'($urandom);
        apply_stimulus(1'b1, 1'b1, wa, d, 1'b0, 12'h000, 1'b0, 1'b0, 8'h00, 1'b0);
        check_output("wr_we", ram_we, 1'b1);
        check_addr("wr_addr", ram_addr, wa);
        check_byte("wr_data", ram_wdata, d);
        step();
        ref_mem[wa] = d;
        apply_stimulus(1'b1, 1'b0, wa, 8'h00, 1'b0, 12'h000, 1'b0, 1'b0, 8'h00, 1'b0);
        check_byte("wr_readback", cpu_mem_rdata, ref_mem[wa]);
        step();

        // Four-byte load; ld_start arrives alongside a CPU read which must still complete
        apply_stimulus(1'b1, 1'b0, 12'h123, 8'h00, 1'b0, 12'h000, 1'b1, 1'b0, 8'h00, 1'b0);
        check_output("t2_start_cpu_en", ram_en, 1'b1);
        check_addr("t2_start_cpu_addr", ram_addr, 12'h123);
        check_output("t2_start_hold", cpu_hold, 1'b0);
        step();
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(1'b0, 1'b1, 12'h010, 8'h55, 1'b0, 12'h000, 1'b0, 1'b1, img4[0], 1'b0);
            check_output("t2_hold_cpu_hold", cpu_hold, 1'b1);
            check_output("t2_hold_busy", ld_busy, 1'b1);
            check_output("t2_hold_ready", ld_ready, 1'b0);
            check_output("t2_hold_cpu_ignored", ram_en, 1'b0);
            step();
        end
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 1'b0, 1'b1, img4[k], k == 3);
            check_output("t2_load_ready", ld_ready, 1'b1);
            check_output("t2_load_we", ram_we, 1'b1);
            check_addr("t2_load_addr", ram_addr, 12'h200 + 12'(k));
            check_byte("t2_load_data", ram_wdata, img4[k]);
            step();
            ref_mem[12'h200 + 12'(k)] = img4[k];
        end
        idle();
        check_output("t2_rel_hold", cpu_hold, 1'b1);
        check_output("t2_rel_busy", ld_busy, 1'b0);
        check_output("t2_rel_ready", ld_ready, 1'b0);
        step();
        check_output("t2_run_hold", cpu_hold, 1'b0);
        check_output("t2_run_busy", ld_busy, 1'b0);
        check_output("t2_run_err", ld_err, 1'b0);
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(1'b1, 1'b0, 12'h200 + 12'(k), 8'h00, 1'b0, 12'h000, 1'b0, 1'b0, 8'h00, 1'b0);
            check_byte("t2_image", cpu_mem_rdata, img4[k]);
            step();
        end

        // Sprite at 0x050 during a load with gaps in ld_valid
        apply_stimulus(1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 12'h050, 1'b1, 1'b0, 8'h00, 1'b0);
        check_output("t3_run_gnt", spr_gnt, 1'b1);
        prev_gnt = 1'b1;
        step();
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 12'h050, 1'b0, 1'b0, 8'h00, 1'b0);
            check_output("t3_hold_gnt", spr_gnt, 1'b1);
            check_output("t3_hold_rvalid", spr_rvalid, prev_gnt);
            check_byte("t3_hold_rdata", spr_rdata, ref_mem[12'h050]);
            prev_gnt = 1'b1;
            step();
        end
        sent = 0;
        for (int c = 0; c < 200 && sent < 6; c++) begin
            v = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            apply_stimulus(1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 12'h050, 1'b0, v, d, v && (sent == 5));
            exp_gnt = !v;
            check_output("t3_load_gnt", spr_gnt, exp_gnt);
            check_output("t3_load_rvalid", spr_rvalid, prev_gnt);
            if (prev_gnt) check_byte("t3_load_rdata", spr_rdata, ref_mem[12'h050]);
            if (v) begin
                check_addr("t3_load_addr", ram_addr, 12'h200 + 12'(sent));
                ref_mem[12'h200 + 12'(sent)] = d;
                sent++;
            end
            prev_gnt = exp_gnt;
            step();
        end
        check_output("t3_all_sent", sent == 6, 1'b1);
        apply_stimulus(1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 12'h050, 1'b0, 1'b0, 8'h00, 1'b0);
        check_output("t3_rel_gnt", spr_gnt, 1'b1);
        check_output("t3_rel_hold", cpu_hold, 1'b1);
        step();
        idle();
        check_output("t3_final_rvalid", spr_rvalid, 1'b1);
        check_byte("t3_final_rdata", spr_rdata, ref_mem[12'h050]);
        check_output("t3_run_hold", cpu_hold, 1'b0);
        step();
        for (int k = 0; k < 6; k++) begin
            apply_stimulus(1'b1, 1'b0, 12'h200 + 12'(k), 8'h00, 1'b0, 12'h000, 1'b0, 1'b0, 8'h00, 1'b0);
            check_byte("t3_image", cpu_mem_rdata, ref_mem[12'h200 + 12'(k)]);
            step();
        end

        // CPU busy every cycle starves the sprite engine
        saddr = 12'($urandom_range(0, 511));
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b1, 1'b0, 12'($urandom_range(0, 4095)), 8'h00, 1'b1, saddr,
                           1'b0, 1'b0, 8'h00, 1'b0);
            check_output("t4_denied", spr_gnt, 1'b0);
            check_output("t4_starve", spr_starve, i >= 8);
            step();
        end
        apply_stimulus(1'b0, 1'b0, 12'h000, 8'h00, 1'b1, saddr, 1'b0, 1'b0, 8'h00, 1'b0);
        check_output("t4_gnt", spr_gnt, 1'b1);
        check_output("t4_starve_held", spr_starve, 1'b1);
        step();
        idle();
        check_output("t4_starve_clear", spr_starve, 1'b0);
        check_output("t4_rvalid", spr_rvalid, 1'b1);
        check_byte("t4_rdata", spr_rdata, ref_mem[saddr]);
        step();

        // Oversized image overruns 0xFFF
        apply_stimulus(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 1'b1, 1'b0, 8'h00, 1'b0);
        step();
        skip_hold();
        for (int k = 1; k <= 3585; k++) begin
            d = 8'($urandom);
            apply_stimulus(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 1'b0, 1'b1, d, k == 3585);
            if (k <= 3584) begin
                ea = 12'h200 + 12'(k - 1);
                check_output("t5_ready", ld_ready, 1'b1);
                check_output("t5_we", ram_we, 1'b1);
                check_addr("t5_addr", ram_addr, ea);
                if (k == 3584) check_output("t5_err_before", ld_err, 1'b0);
                ref_mem[ea] = d;
            end else begin
                check_output("t5_err", ld_err, 1'b1);
                check_output("t5_drop_ready", ld_ready, 1'b0);
                check_output("t5_drop_we", ram_we, 1'b0);
            end
            step();
        end
        idle();
        check_output("t5_rel_hold", cpu_hold, 1'b1);
        check_output("t5_rel_busy", ld_busy, 1'b0);
        step();
        apply_stimulus(1'b1, 1'b0, 12'hFFF, 8'h00, 1'b0, 12'h000, 1'b0, 1'b0, 8'h00, 1'b0);
        check_output("t5_run_hold", cpu_hold, 1'b0);
        check_output("t5_err_sticky", ld_err, 1'b1);
        check_byte("t5_fff", cpu_mem_rdata, ref_mem[12'hFFF]);
        step();

        // Async reset in the middle of a load
        apply_stimulus(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 1'b1, 1'b0, 8'h00, 1'b0);
        step();
        check_output("t6_err_cleared", ld_err, 1'b0);
        skip_hold();
        d = 8'($urandom);
        apply_stimulus(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 1'b0, 1'b1, d, 1'b0);
        check_output("t6_ready", ld_ready, 1'b1);
        step();
        ref_mem[12'h200] = d;
        apply_stimulus(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 1'b0, 1'b1, 8'($urandom), 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("t6_hold_async", cpu_hold, 1'b0);
        check_output("t6_busy_async", ld_busy, 1'b0);
        check_output("t6_ready_async", ld_ready, 1'b0);
        check_output("t6_we_async", ram_we, 1'b0);
        idle();
        @(negedge clk);
        reset_n = 1'b1;
        step();
        apply_stimulus(1'b1, 1'b0, 12'h200, 8'h00, 1'b1, 12'h050, 1'b0, 1'b0, 8'h00, 1'b0);
        check_output("t6_cpu_en", ram_en, 1'b1);
        check_addr("t6_cpu_addr", ram_addr, 12'h200);
        check_byte("t6_cpu_rdata", cpu_mem_rdata, ref_mem[12'h200]);
        check_output("t6_spr_denied", spr_gnt, 1'b0);
        step();
        apply_stimulus(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 1'b1, 1'b0, 8'h00, 1'b0);
        step();
        check_output("t6_restart_hold", cpu_hold, 1'b1);
        check_output("t6_restart_busy", ld_busy, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
